uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//   Parametrised UART receiver. Successor to the fixed 8N1 receiver that feeds the
//   MNIST image loader. Adds configurable baud, data width, parity and stop bits,
//   false-start rejection, and parity/framing error flags. Outputs one word per frame.
// PARAMETERS
//   CLK_FREQ   50_000_000  sys_clk frequency, Hz
//   BAUD       230_400     line rate, bit/s; BIT_CYC = CLK_FREQ/BAUD (integer), HALF = BIT_CYC/2
//   DATA_BITS  8           payload bits per frame, legal range 5..9
//   PARITY     0           0 = none, 1 = odd, 2 = even
//   STOP_BITS  1           1 or 2
// PORTS
//   sys_clk     in   1          system clock
//   sys_rst_n   in   1          asynchronous active-low reset
//   rx_data     in   1          serial line, idles high, asynchronous to sys_clk
//   rx_valid    out  1          one-cycle pulse: frame complete, rx_word and flags updated
//   rx_word     out  DATA_BITS  received payload, LSB first on line; held until next rx_valid
//   parity_err  out  1          parity mismatch in last frame (always 0 when PARITY=0)
//   frame_err   out  1          a stop bit sampled low in last frame
//   rx_busy     out  1          high whenever FSM is not IDLE
// BEHAVIOUR
// - Reset values: all outputs 0. Internal 2-flop synchroniser resets to 1 (line idle),
//   so releasing reset with the line high never creates a start.
// - Start detect: falling edge on the synchronised line (previous 1, current 0) while in IDLE.
// - Baud counter: width $clog2(BIT_CYC). Cleared on every state entry.
// - FSM:
//   - IDLE: on start detect -> START.
//   - START: at cnt==HALF-1, sample the line.
//     - 1 -> IDLE: glitch; no rx_valid, no flags.
//     - 0 -> DATA, bit_idx=0.
//   - DATA: at cnt==BIT_CYC-1 (mid-bit), shift sample into bit bit_idx.
//     After bit DATA_BITS-1: -> PARITY if PARITY!=0, else -> STOP.
//   - PARITY: at cnt==BIT_CYC-1, sample p.
//     odd: error if ^data ^ p == 0. even: error if ^data ^ p == 1.
//   - STOP: sample STOP_BITS bits, each at cnt==BIT_CYC-1; any 0 sets frame error.
//     On the final stop sample edge: register rx_word/parity_err/frame_err, pulse
//     rx_valid for exactly 1 cycle, -> IDLE.
// - Error frames still produce rx_valid with the payload; the consumer decides whether
//   to drop the word. Flags change only on rx_valid.
// - Latency: rx_valid rises (0.5 + DATA_BITS + (PARITY!=0) + STOP_BITS)*BIT_CYC + 3 cycles
//   (+/-1) after the line falling edge (2 synchroniser + 1 edge-detect cycles).
// - Back-to-back frames: FSM returns to IDLE half a stop bit early. A start edge arriving
//   immediately after the stop bit is caught, with no idle gap needed.
// - Break (line held low): 1 frame_err frame, then IDLE. No new frame until line returns
//   high and falls again.
// - Reset mid-frame: FSM -> IDLE immediately, partial word discarded, outputs to reset values.
// - rx_data never drives logic except through the synchroniser.
// TESTING  (CLK_FREQ=50e6, BAUD=230400 -> BIT_CYC=217, HALF=108 unless stated)
// 1. 8N1, send 0xA5 -> single rx_valid pulse, rx_word=0xA5, parity_err=0, frame_err=0,
//    pulse 2064..2066 cycles after falling edge.
// 2. PARITY=2, send 0x3C with p=0 -> rx_word=0x3C, parity_err=0.
//    Same byte with p=1 -> rx_word=0x3C, parity_err=1.
// 3. Line low for 50 cycles then high -> rx_busy high ~110 cycles, no rx_valid,
//    outputs unchanged.
// 4. Send 0x7E with stop bit 0 -> rx_valid, frame_err=1. Hold low 20 bit times -> no
//    further rx_valid. Then idle high, send 0x55 -> rx_word=0x55, both flags 0.
// 5. DATA_BITS=7, STOP_BITS=2, PARITY=1, back-to-back 0x00,0x7F with no gap -> two pulses,
//    words 0x00 then 0x7F, flags 0.
// 6. Assert sys_rst_n low mid-way through bit 4 of 0x81, release, send 0x81 ->
//    outputs 0 during reset, exactly one rx_valid with rx_word=0x81.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised UART receiver (start / DATA_BITS / optional parity / stop bits)
//
// Delivers one word per frame and flags parity and framing errors. A start that is no
// longer low at half a bit time is treated as a glitch and ignored. Frames that contain
// errors are still delivered, so the consumer can decide whether to drop the word.
//
// Ports
//   sys_clk     in   1          system clock
//   sys_rst_n   in   1          asynchronous active-low reset
//   rx_data     in   1          serial line, idles high, asynchronous to sys_clk
//   rx_valid    out  1          one-cycle pulse: frame complete, rx_word and flags updated
//   rx_word     out  DATA_BITS  received payload (LSB first on the line), held until next rx_valid
//   parity_err  out  1          parity mismatch in last frame (always 0 when PARITY=0)
//   frame_err   out  1          a stop bit was sampled low in last frame
//   rx_busy     out  1          high whenever the receiver is not idle
module uart_rx_param #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD      = 230_400,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 rx_data,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_word,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam int BIT_CYC = CLK_FREQ / BAUD;
   localparam int HALF    = BIT_CYC / 2;
   localparam int CNT_W   = $clog2(BIT_CYC);

   localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(BIT_CYC - 1);
   localparam logic [3:0]       BIDX_LAST     = 4'(DATA_BITS - 1);
   localparam logic             STOP_LAST     = 1'(STOP_BITS - 1);
   localparam logic [1:0]       PAR_MODE      = 2'(PARITY);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Parity check: odd mode wants an odd number of ones over data+p, even mode an even number.
   function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
      logic e;
      case (PAR_MODE)
         2'd1:    e = ~(^d ^ p);
         2'd2:    e = ^d ^ p;
         default: e = 1'b0;
      endcase
      return e;
   endfunction

   state_t               state_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [3:0]           bit_idx_r;
   logic                 stop_idx_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 par_err_r;
   logic                 stop_err_r;
   logic                 sync1_r;
   logic                 sync2_r;
   logic                 prev_r;
   logic                 start_s;

   // Two-flop synchroniser plus edge-detect history; reset to idle-high so reset release
   // with the line high never looks like a start edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
      end else begin
         sync1_r <= rx_data;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   assign start_s = prev_r & ~sync2_r;

   // Frame FSM: the counter restarts on every state entry, so samples land at mid-bit.
   // The final stop sample returns to IDLE half a bit early to catch back-to-back starts.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= CNT_ZERO;
         bit_idx_r  <= 4'd0;
         stop_idx_r <= 1'b0;
         shift_r    <= {DATA_BITS{1'b0}};
         par_err_r  <= 1'b0;
         stop_err_r <= 1'b0;
         rx_valid   <= 1'b0;
         rx_word    <= {DATA_BITS{1'b0}};
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         rx_busy    <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               cnt_r <= CNT_ZERO;
               if (start_s) begin
                  state_r <= ST_START;
                  rx_busy <= 1'b1;
               end
            end
            ST_START: begin
               if (cnt_r == CNT_HALF_LAST) begin
                  cnt_r <= CNT_ZERO;
                  if (sync2_r) begin
                     // line back high at mid start bit: glitch, drop it silently
                     state_r <= ST_IDLE;
                     rx_busy <= 1'b0;
                  end else begin
                     state_r   <= ST_DATA;
                     bit_idx_r <= 4'd0;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (cnt_r == CNT_BIT_LAST) begin
                  cnt_r   <= CNT_ZERO;
                  // LSB arrives first, so after DATA_BITS right-shifts it sits in bit 0
                  shift_r <= {sync2_r, shift_r[DATA_BITS-1:1]};
                  if (bit_idx_r == BIDX_LAST) begin
                     state_r    <= (PAR_MODE != 2'd0) ? ST_PARITY : ST_STOP;
                     stop_idx_r <= 1'b0;
                     stop_err_r <= 1'b0;
                     par_err_r  <= 1'b0;
                  end else begin
                     bit_idx_r <= bit_idx_r + 4'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_PARITY: begin
               if (cnt_r == CNT_BIT_LAST) begin
                  cnt_r     <= CNT_ZERO;
                  par_err_r <= parity_error(shift_r, sync2_r);
                  state_r   <= ST_STOP;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_STOP: begin
               if (cnt_r == CNT_BIT_LAST) begin
                  cnt_r <= CNT_ZERO;
                  if (stop_idx_r == STOP_LAST) begin
                     rx_valid   <= 1'b1;
                     rx_word    <= shift_r;
                     parity_err <= par_err_r;
                     frame_err  <= stop_err_r | ~sync2_r;
                     state_r    <= ST_IDLE;
                     rx_busy    <= 1'b0;
                  end else begin
                     stop_idx_r <= 1'b1;
                     stop_err_r <= stop_err_r | ~sync2_r;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= CNT_ZERO;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
